// File: rtl/deca_pmon_i2c_pkg.sv
// Shared constants for the DECA power-monitor I2C master: FSM states, register
// addresses, CMD/STATUS bit positions and the default quarter-period divisor.
package deca_pmon_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  localparam int CMD_START = 8;
  localparam int CMD_STOP  = 9;
  localparam int CMD_READ  = 10;
  localparam int CMD_MACK  = 11;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_RXNACK  = 2;
  localparam int STAT_OVERRUN = 3;
  localparam int STAT_IRQ_EN  = 4;

  // 50 MHz / (4 * 125) = 100 kHz SCL
  localparam int DIV_RESET_DEFAULT = 124;

endpackage

// File: rtl/deca_pmon_i2c_qtick.sv
// Quarter-period tick generator: reloadable down-counter, restartable on command
// acceptance and freezable while the bus is being clock-stretched.
module deca_pmon_i2c_qtick
  import deca_pmon_i2c_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == '0) && !hold;

  // div is only sampled on reload, so a DIV write never disturbs a running quarter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= DIV_W'(DIV_RESET_DEFAULT);
    end else if (restart || tick) begin
      cnt <= div;
    end else if (!hold && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/deca_pmon_i2c_master.sv
// Byte-level I2C master with Avalon-MM register interface and open-drain pin enables.
// Optional macro DECA_PMON_I2C_CLKSTRETCH_EN: wait for SCL high before leaving q1.
module deca_pmon_i2c_master
  import deca_pmon_i2c_pkg::*;
#(
  parameter int DIV_RESET = DIV_RESET_DEFAULT,
  parameter int DIV_W     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        scl_oe,
  input  logic        scl_in,
  output logic        sda_oe,
  input  logic        sda_in
);

  state_t           state, state_n;
  logic [1:0]       q, q_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       sh, rxdata;
  logic             c_stop, c_read, c_mack;
  logic             done, rxnack, overrun, irq_en;
  logic [DIV_W-1:0] div;
  logic             tick, hold, busy, adv, finish, accept;
  logic             cmd_wr, stat_wr, div_wr;
  logic             scl_n, sda_n, tx_bit, rd_mode;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign unused_bits = ^writedata[31:12];

  assign busy    = (state != ST_IDLE);
  assign cmd_wr  = chipselect && !write_n && (address == ADDR_CMD);
  assign stat_wr = chipselect && !write_n && (address == ADDR_STATUS);
  assign div_wr  = chipselect && !write_n && (address == ADDR_DIV);
  assign adv     = busy && tick;
  assign finish  = adv && (q == 2'd3) &&
                   (((state == ST_ACK) && !c_stop) || (state == ST_STOP));
  // the cycle that completes a transfer can already take the next command
  assign accept  = cmd_wr && (!busy || finish);
  assign irq     = done && irq_en;

`ifdef DECA_PMON_I2C_CLKSTRETCH_EN
  assign hold = busy && (q == 2'd1) && !scl_in;
`else
  logic unused_scl;
  assign unused_scl = scl_in;
  assign hold       = 1'b0;
`endif

  deca_pmon_i2c_qtick #(.DIV_W(DIV_W)) u_qtick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (accept),
    .hold    (hold),
    .div     (div),
    .tick    (tick)
  );

  always_comb begin
    state_n   = state;
    q_n       = q;
    bit_cnt_n = bit_cnt;
    if (accept) begin
      state_n   = writedata[CMD_START] ? ST_START : ST_BIT;
      q_n       = 2'd0;
      bit_cnt_n = 3'd0;
    end else if (adv) begin
      q_n = q + 2'd1;
      if (q == 2'd3) begin
        unique case (state)
          ST_START: state_n = ST_BIT;
          ST_BIT: begin
            if (bit_cnt == 3'd7) state_n = ST_ACK;
            else bit_cnt_n = bit_cnt + 3'd1;
          end
          ST_ACK:  state_n = c_stop ? ST_STOP : ST_IDLE;
          default: state_n = ST_IDLE;
        endcase
      end
    end
  end

  // Line actions happen on entry to each quarter; anything not named keeps its level
  always_comb begin
    scl_n   = scl_oe;
    sda_n   = sda_oe;
    tx_bit  = accept ? writedata[7] : sh[7];
    rd_mode = accept ? writedata[CMD_READ] : c_read;
    if (accept || adv) begin
      unique case (state_n)
        ST_START: begin
          unique case (q_n)
            2'd0: sda_n = 1'b0;
            2'd1: scl_n = 1'b0;
            2'd2: sda_n = 1'b1;
            default: scl_n = 1'b1;
          endcase
        end
        ST_BIT: begin
          unique case (q_n)
            2'd0: sda_n = !rd_mode && !tx_bit;
            2'd1: scl_n = 1'b0;
            2'd2: ;
            default: scl_n = 1'b1;
          endcase
        end
        ST_ACK: begin
          unique case (q_n)
            2'd0: sda_n = c_read && !c_mack;
            2'd1: scl_n = 1'b0;
            2'd2: ;
            default: scl_n = 1'b1;
          endcase
        end
        ST_STOP: begin
          unique case (q_n)
            2'd0: sda_n = 1'b1;
            2'd1: scl_n = 1'b0;
            2'd2: sda_n = 1'b0;
            default: ;
          endcase
        end
        default: sda_n = 1'b0;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_RXDATA: rd_mux[7:0] = rxdata;
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY]    = busy;
        rd_mux[STAT_DONE]    = done;
        rd_mux[STAT_RXNACK]  = rxnack;
        rd_mux[STAT_OVERRUN] = overrun;
        rd_mux[STAT_IRQ_EN]  = irq_en;
      end
      ADDR_DIV: rd_mux[DIV_W-1:0] = div;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      q        <= 2'd0;
      bit_cnt  <= 3'd0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      c_stop   <= 1'b0;
      c_read   <= 1'b0;
      c_mack   <= 1'b0;
      done     <= 1'b0;
      rxnack   <= 1'b0;
      overrun  <= 1'b0;
      irq_en   <= 1'b0;
      rxdata   <= 8'd0;
      div      <= DIV_W'(DIV_RESET);
      readdata <= 32'd0;
    end else begin
      state    <= state_n;
      q        <= q_n;
      bit_cnt  <= bit_cnt_n;
      scl_oe   <= scl_n;
      sda_oe   <= sda_n;
      readdata <= rd_mux;
      if (accept) begin
        c_stop <= writedata[CMD_STOP];
        c_read <= writedata[CMD_READ];
        c_mack <= writedata[CMD_MACK];
      end
      if (adv && (state == ST_ACK) && (q == 2'd2) && !c_read) rxnack <= sda_in;
      if (finish && c_read) rxdata <= sh;
      // a new command beats completion, completion beats a software clear
      if (accept) done <= 1'b0;
      else if (finish) done <= 1'b1;
      else if (stat_wr && writedata[STAT_DONE]) done <= 1'b0;
      if (cmd_wr && busy && !finish) overrun <= 1'b1;
      else if (stat_wr && writedata[STAT_OVERRUN]) overrun <= 1'b0;
      if (stat_wr) irq_en <= writedata[STAT_IRQ_EN];
      if (div_wr) div <= writedata[DIV_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) sh <= writedata[7:0];
    else if (adv && (state == ST_BIT) && (q == 2'd2)) sh <= {sh[6:0], sda_in};
  end

endmodule

// File: tb/tb_deca_pmon_i2c_master.sv
// Self-checking bench for deca_pmon_i2c_master: slave model on the pins plus an
// SDA-at-SCL-rise scoreboard; register and latency checks per scenario.
module tb_deca_pmon_i2c_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq, scl_oe, scl_in, sda_oe, sda_in;

  int checks = 0;
  int fails = 0;

  logic exp_q[$];
  logic slave_q[$];
  logic slave_sda = 1'b1;
  int   stretch_cnt = 0;
  int   stretch_arm = 0;
  logic prev_scl = 1'b0;

  always #5 clk = ~clk;

  assign scl_in = !scl_oe && (stretch_cnt == 0);
  assign sda_in = !sda_oe && slave_sda;

  deca_pmon_i2c_master #(.DIV_RESET(124), .DIV_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .scl_oe     (scl_oe),
    .scl_in     (scl_in),
    .sda_oe     (sda_oe),
    .sda_in     (sda_in)
  );

  // Slave: presents the queue head on SDA, advances on every SCL fall.
  // Scoreboard: on every SCL release compare the SDA line with the next expected bit.
  always @(negedge clk) begin
    logic e;
    if (stretch_cnt > 0) stretch_cnt = stretch_cnt - 1;
    if (!prev_scl && scl_oe) begin
      if (slave_q.size() > 0) void'(slave_q.pop_front());
      if (stretch_arm == 1) stretch_arm = 2;
    end
    if (prev_scl && !scl_oe) begin
      if (stretch_arm == 2) begin
        stretch_cnt = 20;
        stretch_arm = 0;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sda_in !== e) begin
          fails++;
          $display("FAIL sda_at_scl_rise: got %0b expected %0b at %0t", sda_in, e, $time);
        end
      end
    end
    prev_scl = scl_oe;
    slave_sda = (slave_q.size() > 0) ? slave_q[0] : 1'b1;
  end

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  // Counts clk edges from acceptance until irq; optionally fires a CMD write at edge ov
  task automatic wait_done(input int ov, output int n);
    n = 0;
    while (n < 2000) begin
      if (n == ov) begin
        address = 2'd0; writedata = 32'h3FF; chipselect = 1'b1; write_n = 1'b0;
      end
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      n++;
      if (irq) break;
    end
  endtask

  task automatic load_write_slave(input logic [7:0] data, input logic ack_bit);
    slave_q.delete(); exp_q.delete();
    for (int i = 0; i < 9; i++) slave_q.push_back(1'b1);
    slave_q.push_back(ack_bit);
    slave_q.push_back(1'b1);
    for (int i = 7; i >= 0; i--) exp_q.push_back(data[i]);
    exp_q.push_back(ack_bit);
    exp_q.push_back(1'b0);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({scl_oe, sda_oe, irq} !== 3'b000 || readdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got scl=%0b sda=%0b irq=%0b rd=%0h expected all 0", scl_oe, sda_oe, irq, readdata);
    end
    reset_n = 1'b1;
    reg_read(2'd3, d);
    checks++;
    if (d !== 32'd124) begin fails++; $display("FAIL reset_div: got %0d expected 124", d); end
    reg_read(2'd2, d);
    checks++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_status: got %0h expected 0", d); end
    reg_read(2'd1, d);
    checks++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_rxdata: got %0h expected 0", d); end
  endtask

  task automatic test_write();
    logic [31:0] d;
    int n;
    reg_write(2'd3, 32'd3);
    reg_write(2'd2, 32'h10);
    load_write_slave(8'hA5, 1'b0);
    reg_write(2'd0, 32'h3A5);
    wait_done(-1, n);
    checks++;
    if (n !== 176) begin fails++; $display("FAIL write_latency: got %0d expected 176", n); end
    reg_read(2'd2, d);
    checks++;
    if (d !== 32'h12) begin fails++; $display("FAIL write_status: got %0h expected 12", d); end
    checks++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL write_sda_count: got %0d left expected 0", exp_q.size()); end
    reg_write(2'd2, 32'h00);
    checks++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_masked: got %0b expected 0", irq); end
    reg_write(2'd2, 32'h10);
    checks++;
    if (irq !== 1'b1) begin fails++; $display("FAIL irq_unmasked: got %0b expected 1", irq); end
    reg_write(2'd2, 32'h12);
    checks++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_done_clear: got %0b expected 0", irq); end
  endtask

  task automatic test_read();
    logic [31:0] d;
    logic [7:0]  data;
    int n;
    data = 8'h3C;
    slave_q.delete(); exp_q.delete();
    for (int i = 7; i >= 0; i--) slave_q.push_back(data[i]);
    slave_q.push_back(1'b1);
    // SCL is already released when bit 0 starts, so its rise is not seen
    for (int i = 6; i >= 0; i--) exp_q.push_back(data[i]);
    exp_q.push_back(1'b1);
    reg_write(2'd0, 32'hCFF);
    wait_done(-1, n);
    checks++;
    if (n !== 144) begin fails++; $display("FAIL read_latency: got %0d expected 144", n); end
    reg_read(2'd1, d);
    checks++;
    if (d !== 32'h3C) begin fails++; $display("FAIL read_rxdata: got %0h expected 3c", d); end
    reg_read(2'd2, d);
    checks++;
    if (d !== 32'h12) begin fails++; $display("FAIL read_status: got %0h expected 12", d); end
    checks++;
    if (scl_oe !== 1'b1) begin fails++; $display("FAIL read_scl_held: got %0b expected 1", scl_oe); end
    checks++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL read_sda_count: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_nack_overrun();
    logic [31:0] d;
    int n;
    load_write_slave(8'h90, 1'b1);
    // SCL starts held low, so the START q1 release is observed with SDA high
    exp_q.push_front(1'b1);
    reg_write(2'd0, 32'h390);
    wait_done(40, n);
    checks++;
    if (n !== 176) begin fails++; $display("FAIL nack_latency: got %0d expected 176", n); end
    reg_read(2'd2, d);
    checks++;
    if (d !== 32'h1E) begin fails++; $display("FAIL nack_status: got %0h expected 1e", d); end
    checks++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL nack_sda_count: got %0d left expected 0", exp_q.size()); end
    reg_read(2'd1, d);
    checks++;
    if (d !== 32'h3C) begin fails++; $display("FAIL nack_rxdata_kept: got %0h expected 3c", d); end
    reg_write(2'd2, 32'h1A);
    reg_read(2'd2, d);
    checks++;
    if (d !== 32'h14) begin fails++; $display("FAIL status_clear: got %0h expected 14", d); end
  endtask

  task automatic test_reset_mid_byte();
    logic [31:0] d;
    slave_q.delete(); exp_q.delete();
    reg_write(2'd0, 32'h155);
    repeat (86) @(posedge clk);
    #1;
    reg_read(2'd2, d);
    checks++;
    if (d[0] !== 1'b1) begin fails++; $display("FAIL mid_busy: got %0b expected 1", d[0]); end
    checks++;
    if (sda_oe !== 1'b1) begin fails++; $display("FAIL mid_sda_driven: got %0b expected 1", sda_oe); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({scl_oe, sda_oe} !== 2'b00) begin fails++; $display("FAIL mid_reset_lines: got scl=%0b sda=%0b expected 0 0", scl_oe, sda_oe); end
    reset_n = 1'b1;
    reg_read(2'd2, d);
    checks++;
    if (d !== 32'd0) begin fails++; $display("FAIL mid_reset_status: got %0h expected 0", d); end
  endtask

  task automatic test_clock_stretch();
    logic [31:0] d;
    int n, want;
`ifdef DECA_PMON_I2C_CLKSTRETCH_EN
    want = 196;
`else
    want = 176;
`endif
    reg_write(2'd3, 32'd3);
    reg_write(2'd2, 32'h10);
    load_write_slave(8'hA5, 1'b0);
    stretch_arm = 1;
    reg_write(2'd0, 32'h3A5);
    wait_done(-1, n);
    checks++;
    if (n !== want) begin fails++; $display("FAIL stretch_latency: got %0d expected %0d", n, want); end
    reg_read(2'd2, d);
    checks++;
    if (d !== 32'h12) begin fails++; $display("FAIL stretch_status: got %0h expected 12", d); end
    checks++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL stretch_sda_count: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack_overrun();
    test_reset_mid_byte();
    test_clock_stretch();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/deca_pmon_i2c_master.md
# deca_pmon_i2c_master

Byte-level I2C master for the DECA power-monitor subsystem. It replaces software bit-banging of the SCL/SDA PIOs, using an Avalon-MM slave for the Nios and open-drain pin controls toward the top level. Software issues one command per byte (optional START, 8 data bits, ACK slot, optional STOP), then polls status or takes the interrupt.

## Interface
Parameters:
- DIV_RESET, 124: reset value of the quarter-period divider; 50 MHz / (4·125) gives 100 kHz SCL.
- DIV_W, 16: divider register width.

Ports:
- clk  in  1  system clock; the block has one clock.
- reset_n  in  1  synchronous, active-low reset.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  Avalon write data.
- readdata  out  32  registered Avalon read data.
- irq  out  1  level interrupt, asserted while DONE=1 and IRQ_EN=1.
- scl_oe  out  1  1 drives SCL low; 0 releases it.
- scl_in  in  1  sampled SCL pin.
- sda_oe  out  1  1 drives SDA low; 0 releases it.
- sda_in  in  1  sampled SDA pin.

## Operation
Register map:
- **0 CMD (write):** [7:0] TXDATA, [8] START, [9] STOP, [10] READ, [11] MACK. With READ=1, MACK=1 sends NACK. Reads return 0.
- **1 RXDATA (read):** [7:0] last received byte.
- **2 STATUS:** [0] BUSY, [1] DONE, [2] RXNACK, [3] OVERRUN, [4] IRQ_EN. A write clears DONE/OVERRUN where the written bit is 1, and loads IRQ_EN from bit 4.
- **3 DIV:** [DIV_W-1:0] quarter-period divisor.

Command acceptance:
- A CMD write with BUSY=0 is accepted. BUSY sets the next cycle and DONE clears.
- A CMD write with BUSY=1 is ignored and OVERRUN is set (sticky).

Quarter tick: pulses once every DIV+1 clk cycles. The counter restarts at command acceptance.

FSM states: IDLE → START (if START) → BIT ×8 → ACK → STOP (if STOP) → IDLE. Each non-IDLE state spans quarters q0..q3:
- **START:** q0 release SDA; q1 release SCL; q2 drive SDA low; q3 drive SCL low. This also works as a repeated START.
- **BIT (MSB first):** q0 SDA = TX bit (write), or released (read); q1 release SCL; q2 sample sda_in into the shift register; q3 drive SCL low.
- **ACK:**
  - Write: SDA released; sda_in sampled at q2 gives RXNACK.
  - Read: SDA driven low for ACK (MACK=0), released for NACK.
- **STOP:** q0 drive SDA low; q1 release SCL; q2 release SDA; q3 hold.
- On leaving the last state: BUSY clears, DONE sets, and RXDATA updates if READ=1.

Other rules:
- Without STOP, SCL stays driven low after ACK q3, holding the bus for the next command.
- A DIV write takes effect at the next tick reload. The value is not re-latched mid-quarter.
- DIV=0 gives one tick per clk, the minimum legal setting.

## Timing
- readdata is registered with 1-cycle latency, sampled on any cycle (chipselect is not required), matching the existing PIOs.
- Reset values:
  - readdata=0, irq=0, scl_oe=0, sda_oe=0.
  - BUSY/DONE/RXNACK/OVERRUN/IRQ_EN=0, RXDATA=0, DIV=DIV_RESET, FSM=IDLE.
- Reset mid-transfer releases both lines in the cycle after reset_n is sampled low. No STOP is generated; software performs bus recovery.
- Transfer latency from acceptance to DONE is Q·(DIV+1) clk, where Q = 4·(9 + START + STOP). The ± clock-stretch wait applies when enabled.
- A CMD write in the same cycle that DONE sets is accepted; DONE ends 0.
- A DONE-clear write in the same cycle that DONE sets leaves DONE=1 (set wins).

## Configuration
- `DECA_PMON_I2C_CLKSTRETCH_EN` defined: after releasing SCL at q1, the FSM does not advance to q2 until scl_in=1. The tick counter is held during the wait.
- Undefined: scl_in is ignored and timing is purely divider-driven.

## Structure
- Package `deca_pmon_i2c_pkg` holds:
  - the FSM state enum;
  - register address constants (CMD/RXDATA/STATUS/DIV);
  - CMD and STATUS bit-index constants;
  - the DIV_RESET default.
- One sub-module, `deca_pmon_i2c_qtick`: loadable down-counter producing the quarter tick, with restart and hold inputs.

## Test plan
- **Reset:** hold reset_n=0 for 3 cycles → all outputs 0, DIV reads 124.
- **Write transfer:** DIV=3, CMD=0x3A5 (START|STOP, data 0xA5), slave ACKs → SDA bit pattern 1010_0101, RXNACK=0, DONE exactly 176 clk after acceptance, irq follows IRQ_EN.
- **Read transfer:** DIV=3, CMD=0x4FF|MACK (READ, NACK, no START/STOP), slave returns 0x3C → RXDATA=0x3C, SDA released in the ACK slot, SCL held low afterwards, DONE after 144 clk.
- **NACK and overrun:** slave NACKs the address byte → RXNACK=1; a CMD write while BUSY → OVERRUN=1 and the transfer continues unchanged.
- **Reset mid-byte:** reset_n low during BIT 4 → scl_oe=sda_oe=0 next cycle, BUSY=0.
- **Clock stretching (macro defined):** slave holds SCL low for 20 clk in bit 0 → DONE delayed by exactly 20 clk. With the macro undefined, no delay.
